// File: rtl/slv_rst_ctrl.sv
// Subordinate reset sequencer: isolate, timed reset pulse, settle, report done.
// Optional isolation watchdog: define SLV_RST_CTRL_TIMEOUT_EN.
module slv_rst_ctrl #(
    parameter int RstCycles    = 16,
    parameter int SettleCycles = 4,
    parameter int IsoTimeout   = 256,
    parameter int CntWidth     = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rst_req_i,
    output logic                isolate_o,
    input  logic                isolated_i,
    output logic                slv_rst_no,
    output logic                rst_stat_o,
    output logic                done_o,
    output logic [CntWidth-1:0] rst_cnt_o,
    output logic                iso_timeout_o,
    input  logic                clr_i
);

    localparam int MaxRs  = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
    localparam int MaxAll = (MaxRs > IsoTimeout) ? MaxRs : IsoTimeout;
    localparam int CW     = $clog2(MaxAll + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISOLATE,
        RESET,
        SETTLE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CntWidth-1:0] rst_cnt_q, rst_cnt_d;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
    logic                iso_to_q, iso_to_d;
    logic                iso_set;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rst_cnt_q <= '0;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
            iso_to_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_cnt_q <= rst_cnt_d;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
            iso_to_q  <= iso_to_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
        iso_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rst_req_i) begin
                    state_d = ISOLATE;
`ifdef SLV_RST_CTRL_TIMEOUT_EN
                    cnt_d   = CW'(IsoTimeout);
`endif
                end
            end
            ISOLATE: begin
                // An acknowledge in the same cycle as expiry wins over the watchdog.
                if (isolated_i) begin
                    state_d = RESET;
                    cnt_d   = CW'(RstCycles);
`ifdef SLV_RST_CTRL_TIMEOUT_EN
                end else if (cnt_q == CW'(1)) begin
                    iso_set = 1'b1;
                    state_d = RESET;
                    cnt_d   = CW'(RstCycles);
                end else begin
                    cnt_d   = cnt_q - CW'(1);
`endif
                end
            end
            RESET: begin
                if (cnt_q == CW'(1)) begin
                    if (SettleCycles == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = CW'(SettleCycles);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (clr_i) begin
            rst_cnt_d = '0;
        end else if ((state_q == DONE) && (rst_cnt_q != {CntWidth{1'b1}})) begin
            rst_cnt_d = rst_cnt_q + CntWidth'(1);
        end
    end

`ifdef SLV_RST_CTRL_TIMEOUT_EN
    always_comb begin
        iso_to_d = iso_to_q;
        if (clr_i) begin
            iso_to_d = 1'b0;
        end else if (iso_set) begin
            iso_to_d = 1'b1;
        end
    end
    assign iso_timeout_o = iso_to_q;
`else
    assign iso_timeout_o = 1'b0;
`endif

    // Outputs decode the state register only; no input reaches an output combinationally.
    assign isolate_o  = (state_q == ISOLATE) || (state_q == RESET) || (state_q == SETTLE);
    assign slv_rst_no = (state_q != RESET);
    assign rst_stat_o = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign rst_cnt_o  = rst_cnt_q;

endmodule

// File: tb/tb_slv_rst_ctrl.sv
// Directed bench for slv_rst_ctrl: main sequence, delayed ack, back-to-back, reset, stall, saturation.
module tb_slv_rst_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i, rst_req_i, isolated_i, clr_i;
    logic       isolate_o, slv_rst_no, rst_stat_o, done_o, iso_timeout_o;
    logic [7:0] rst_cnt_o;

    logic       s_req, s_clr;
    logic       s_iso, s_nrst, s_stat, s_done, s_ito;
    logic [1:0] s_cnt;

    int cyc    = 0;
    int errs   = 0;
    int checks = 0;
    int exp_cnt;
    int d0, m0;

    always #5 clk_i = ~clk_i;

    slv_rst_ctrl #(
        .RstCycles   (16),
        .SettleCycles(4),
        .IsoTimeout  (8),
        .CntWidth    (8)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rst_req_i    (rst_req_i),
        .isolate_o    (isolate_o),
        .isolated_i   (isolated_i),
        .slv_rst_no   (slv_rst_no),
        .rst_stat_o   (rst_stat_o),
        .done_o       (done_o),
        .rst_cnt_o    (rst_cnt_o),
        .iso_timeout_o(iso_timeout_o),
        .clr_i        (clr_i)
    );

    slv_rst_ctrl #(
        .RstCycles   (2),
        .SettleCycles(0),
        .IsoTimeout  (8),
        .CntWidth    (2)
    ) u_sat (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rst_req_i    (s_req),
        .isolate_o    (s_iso),
        .isolated_i   (1'b1),
        .slv_rst_no   (s_nrst),
        .rst_stat_o   (s_stat),
        .done_o       (s_done),
        .rst_cnt_o    (s_cnt),
        .iso_timeout_o(s_ito),
        .clr_i        (s_clr)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s (cycle %0d): observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // which: 0 = main done_o, 1 = saturation-instance done, 2 = main slv_rst_no low
    task automatic wait_for(input int which, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            case (which)
                0:       hit = (done_o === 1'b1);
                1:       hit = (s_done === 1'b1);
                default: hit = (slv_rst_no === 1'b0);
            endcase
            if (!hit) tick();
        end
        checks++;
        assert (hit === 1'b1) else begin
            errs++;
            $error("FAIL %s: event not seen within budget, observed=0 expected=1", tag);
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        rst_req_i  = 1'b0;
        isolated_i = 1'b1;
        clr_i      = 1'b0;
        s_req      = 1'b0;
        s_clr      = 1'b0;
        tick(); tick(); tick();
        rst_i = 1'b0;

        // reset state
        chk("rst_isolate", isolate_o, 0);
        chk("rst_nrst", slv_rst_no, 1);
        chk("rst_stat", rst_stat_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", rst_cnt_o, 0);
        chk("rst_ito", iso_timeout_o, 0);
        chk("rst_sat_cnt", s_cnt, 0);

        // main sequence: one-cycle request at cycle 10
        while (cyc < 10) tick();
        rst_req_i = 1'b1;
        tick();
        rst_req_i = 1'b0;
        while (cyc <= 33) begin
            chk("main_stat", rst_stat_o, (cyc >= 11 && cyc <= 32) ? 1 : 0);
            chk("main_nrst", slv_rst_no, (cyc >= 12 && cyc <= 27) ? 0 : 1);
            chk("main_done", done_o, (cyc == 32) ? 1 : 0);
            chk("main_iso", isolate_o, (cyc >= 11 && cyc <= 31) ? 1 : 0);
            tick();
        end
        chk("main_cnt", rst_cnt_o, 1);
        exp_cnt = 1;

        // delayed acknowledge; later drop of isolated_i must be ignored
        isolated_i = 1'b0;
        rst_req_i  = 1'b1;
        tick();
        rst_req_i = 1'b0;
        chk("dly_iso_on", isolate_o, 1);
        tick(); tick(); tick(); tick(); tick();
        chk("dly_wait_iso", isolate_o, 1);
        chk("dly_wait_nrst", slv_rst_no, 1);
        isolated_i = 1'b1;
        m0 = cyc;
        tick();
        isolated_i = 1'b0;
        while (cyc <= m0 + 16) begin
            chk("dly_nrst_low", slv_rst_no, 0);
            tick();
        end
        chk("dly_nrst_rel", slv_rst_no, 1);
        chk("dly_settle_iso", isolate_o, 1);
        wait_for(0, "dly_done");
        chk("dly_done_at", cyc, m0 + 21);
        tick();
        exp_cnt++;
        chk("dly_cnt", rst_cnt_o, exp_cnt);

        // request held high: back-to-back sequences with one idle cycle
        isolated_i = 1'b1;
        rst_req_i  = 1'b1;
        wait_for(0, "b2b_done1");
        d0 = cyc;
        tick();
        exp_cnt++;
        chk("b2b_gap_stat", rst_stat_o, 0);
        chk("b2b_cnt1", rst_cnt_o, exp_cnt);
        tick();
        chk("b2b_restart_stat", rst_stat_o, 1);
        chk("b2b_restart_iso", isolate_o, 1);
        wait_for(0, "b2b_done2");
        chk("b2b_done2_at", cyc, d0 + 23);
        rst_req_i = 1'b0;
        tick();
        exp_cnt++;
        chk("b2b_cnt2", rst_cnt_o, exp_cnt);
        chk("b2b_idle", rst_stat_o, 0);

        // synchronous reset in the middle of RESET
        rst_req_i = 1'b1;
        tick();
        rst_req_i = 1'b0;
        wait_for(2, "mid_enter_reset");
        tick(); tick(); tick();
        chk("mid_pre_nrst", slv_rst_no, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_nrst", slv_rst_no, 1);
        chk("mid_stat", rst_stat_o, 0);
        chk("mid_iso", isolate_o, 0);
        chk("mid_done", done_o, 0);
        chk("mid_cnt", rst_cnt_o, 0);
        tick(); tick(); tick();
        chk("mid_stay_idle", rst_stat_o, 0);

`ifdef SLV_RST_CTRL_TIMEOUT_EN
        // watchdog: flag 8 cycles after ISOLATE entry, reset pulse still issued
        isolated_i = 1'b0;
        rst_req_i  = 1'b1;
        tick();
        rst_req_i = 1'b0;
        m0 = cyc;
        while (cyc < m0 + 8) begin
            chk("to_pending", iso_timeout_o, 0);
            tick();
        end
        chk("to_flag", iso_timeout_o, 1);
        chk("to_nrst", slv_rst_no, 0);
        wait_for(0, "to_done");
        tick();
        chk("to_sticky", iso_timeout_o, 1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("to_clr", iso_timeout_o, 0);
        isolated_i = 1'b1;
`else
        // no watchdog: ISOLATE waits indefinitely
        isolated_i = 1'b0;
        rst_req_i  = 1'b1;
        tick();
        rst_req_i = 1'b0;
        repeat (1000) tick();
        chk("stall_iso", isolate_o, 1);
        chk("stall_nrst", slv_rst_no, 1);
        chk("stall_stat", rst_stat_o, 1);
        chk("stall_ito", iso_timeout_o, 0);
        isolated_i = 1'b1;
        wait_for(0, "stall_done");
        tick();
        chk("stall_cnt", rst_cnt_o, 1);
`endif

        // saturation with a 2-bit counter and no settle phase
        s_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_for(1, "sat_done");
            tick();
            chk("sat_cnt", s_cnt, (k > 3) ? 3 : k);
            chk("sat_gap", s_stat, 0);
        end
        wait_for(1, "sat_done_clr");
        s_req = 1'b0;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        chk("sat_clr", s_cnt, 0);
        chk("sat_ito", s_ito, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
